// File: rtl/led_flow_gen.sv
// Running-light source for one selector lane: a clock divider sets the step
// rate, and a 3-bit one-hot pattern rotates in a fixed direction on each step.
module led_flow_gen #(
   parameter int CLK_FREQ = 50_000_000,
   parameter int STEP_HZ  = 2,
   parameter int DIR      = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       restart,
   output logic [2:0] led,
   output logic       step
);

   localparam int DIV   = CLK_FREQ / STEP_HZ;
   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [2:0]       LED_START = 3'b001;

   if (DIV < 2) begin : g_div_check
      $error("led_flow_gen: CLK_FREQ / STEP_HZ must be at least 2");
   end

   logic [CNT_W-1:0] cnt_r;
   logic [2:0]       led_r;
   logic             step_r;

   function automatic logic is_one_hot(input logic [2:0] v);
      case (v)
         3'b001, 3'b010, 3'b100: return 1'b1;
         default:                return 1'b0;
      endcase
   endfunction

   // A corrupted (non-one-hot) pattern falls back to the start pattern.
   function automatic logic [2:0] next_pattern(input logic [2:0] v);
      if (!is_one_hot(v)) begin
         return LED_START;
      end else if (DIR == 0) begin
         return {v[1:0], v[2]};
      end else begin
         return {v[0], v[2:1]};
      end
   endfunction

   // Divider, pattern rotator and step strobe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r  <= '0;
         led_r  <= LED_START;
         step_r <= 1'b0;
      end else if (restart) begin
         cnt_r  <= '0;
         led_r  <= LED_START;
         step_r <= 1'b0;
      end else if (!en) begin
         step_r <= 1'b0;
      end else if (cnt_r == CNT_LAST) begin
         cnt_r  <= '0;
         led_r  <= next_pattern(led_r);
         step_r <= 1'b1;
      end else begin
         cnt_r  <= cnt_r + CNT_ONE;
         step_r <= 1'b0;
      end
   end

   assign led  = led_r;
   assign step = step_r;

endmodule

// File: tb/tb_led_flow_gen.sv
// Directed bench for led_flow_gen: forward and reverse instances share stimulus,
// DIV = 10, and every observation is packed as {step, led}.
module tb_led_flow_gen;

   logic       clk;
   logic       rst;
   logic       en;
   logic       restart;
   logic [2:0] led_f;
   logic       step_f;
   logic [2:0] led_r;
   logic       step_r;

   int vectors;
   int miscompares;
   int steps_f;
   int steps_r;

   logic [2:0] fwd_seq [3];
   logic [2:0] rev_seq [3];
   logic [2:0] exp_f;
   logic [2:0] exp_r;
   logic       exp_s;

   led_flow_gen #(.CLK_FREQ(20), .STEP_HZ(2), .DIR(0)) dut_fwd (
      .clk(clk), .rst(rst), .en(en), .restart(restart), .led(led_f), .step(step_f)
   );

   led_flow_gen #(.CLK_FREQ(20), .STEP_HZ(2), .DIR(1)) dut_rev (
      .clk(clk), .rst(rst), .en(en), .restart(restart), .led(led_r), .step(step_r)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got {step,led}=%b expected %b", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_both(input string tag, input logic s, input logic [2:0] lf, input logic [2:0] lr);
      check({tag, "_fwd"}, {step_f, led_f}, {s, lf});
      check({tag, "_rev"}, {step_r, led_r}, {s, lr});
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      steps_f = 0;
      steps_r = 0;
      fwd_seq[0] = 3'b010; fwd_seq[1] = 3'b100; fwd_seq[2] = 3'b001;
      rev_seq[0] = 3'b100; rev_seq[1] = 3'b010; rev_seq[2] = 3'b001;
      rst = 1'b1;
      en = 1'b0;
      restart = 1'b0;

      tick(2);
      check_both("reset", 1'b0, 3'b001, 3'b001);

      // Forward/reverse run: 30 enabled edges, step every 10th.
      rst = 1'b0;
      en  = 1'b1;
      for (int e = 1; e <= 30; e++) begin
         tick(1);
         exp_s = (e % 10 == 0);
         exp_f = (e < 10) ? 3'b001 : fwd_seq[e / 10 - 1];
         exp_r = (e < 10) ? 3'b001 : rev_seq[e / 10 - 1];
         check_both($sformatf("run_e%0d", e), exp_s, exp_f, exp_r);
         if (step_f) steps_f++;
         if (step_r) steps_r++;
      end
      check("step_count_fwd", 4'(steps_f), 4'd3);
      check("step_count_rev", 4'(steps_r), 4'd3);

      // Async reset while outputs show 010/100 with step high, no edge.
      tick(10);
      check_both("pre_async", 1'b1, 3'b010, 3'b100);
      #2;
      rst = 1'b1;
      #1;
      check_both("async_rst", 1'b0, 3'b001, 3'b001);
      tick(1);
      rst = 1'b0;

      // Enable gating: 6 counted edges, 50 frozen, 4 more to the step.
      tick(6);
      check_both("gate_pre", 1'b0, 3'b001, 3'b001);
      en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick(10);
         check_both($sformatf("gate_hold%0d", i), 1'b0, 3'b001, 3'b001);
      end
      en = 1'b1;
      tick(3);
      check_both("gate_re3", 1'b0, 3'b001, 3'b001);
      tick(1);
      check_both("gate_step", 1'b1, 3'b010, 3'b100);
      tick(1);
      check_both("gate_post", 1'b0, 3'b010, 3'b100);

      // Restart on the terminal-count edge (cnt currently 1, reach 9).
      tick(8);
      check_both("rs_pre", 1'b0, 3'b010, 3'b100);
      restart = 1'b1;
      tick(1);
      restart = 1'b0;
      check_both("rs_hit", 1'b0, 3'b001, 3'b001);
      tick(9);
      check_both("rs_wait", 1'b0, 3'b001, 3'b001);
      tick(1);
      check_both("rs_step", 1'b1, 3'b010, 3'b100);

      // Corruption recovery: illegal pattern falls back to 001 at the next step.
      force dut_fwd.led_r = 3'b011;
      force dut_rev.led_r = 3'b011;
      #1;
      release dut_fwd.led_r;
      release dut_rev.led_r;
      tick(9);
      check_both("seu_hold", 1'b0, 3'b011, 3'b011);
      tick(1);
      check_both("seu_fix", 1'b1, 3'b001, 3'b001);
      tick(10);
      check_both("seu_next1", 1'b1, 3'b010, 3'b100);
      tick(10);
      check_both("seu_next2", 1'b1, 3'b100, 3'b010);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
